// File: rtl/uc_pkg.sv
// Shared constants for the microcontroller slice.
// Holds the program-loader FSM state encodings, the default frame start byte
// and a small decode helper for the loader's byte-stream ready signal.
package uc_pkg;

  // Default frame start byte for the program loader
  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  // Width of the frame length field; 4095 words is the largest frame
  localparam int unsigned LEN_W = 12;

  // Program-loader FSM state encodings
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LEN_HI  = 3'd1;
  localparam logic [2:0] ST_LEN_LO  = 3'd2;
  localparam logic [2:0] ST_DATA_HI = 3'd3;
  localparam logic [2:0] ST_DATA_LO = 3'd4;
  localparam logic [2:0] ST_CHECK   = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;
  localparam logic [2:0] ST_ERROR   = 3'd7;

  // The loader takes bytes in every state except DONE and ERROR
  function automatic logic state_rx_ready(input logic [2:0] st);
    return (st != ST_DONE) && (st != ST_ERROR);
  endfunction

endpackage

// File: rtl/prog_loader.sv
// Program loader: receives a framed byte stream and writes 16-bit instruction
// words into instruction memory, holding the core in bootstrap until a frame
// with a correct checksum has been loaded.
//
// Frame: HEADER, LEN[11:8] (low nibble), LEN[7:0], LEN x {HI, LO}, CHECKSUM
// where CHECKSUM is the mod-256 sum of the data bytes only.
//
// Ports:
//   clk, arst_n        system clock, asynchronous active-low reset
//   clk_valid          clock enable; state only moves on enabled edges
//   rx_valid/rx_data   incoming byte stream, accepted with rx_ready
//   rx_ready           loader can take a byte
//   imem_we/addr/wdata instruction-memory write port (one-cycle pulses)
//   bootstrapping      high while the core must stay in program load
//   boot_req           reload request, honoured only once loading is done
//   boot_err           one-cycle pulse on checksum failure
module prog_loader
  import uc_pkg::*;
#(
  parameter logic [7:0]  HEADER = HEADER_DEFAULT,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              clk_valid,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              bootstrapping,
  input  logic              boot_req,
  output logic              boot_err
);

  logic [2:0]        state_q, state_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        csum_q, csum_d;
  logic [7:0]        hi_q, hi_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              boot_q, boot_d;

  logic             accept;
  logic [LEN_W-1:0] len_new;
  logic [LEN_W-1:0] addr_inc;

  assign rx_ready = state_rx_ready(state_q);
  assign accept   = rx_valid && rx_ready && clk_valid;
  assign len_new  = {count_q[LEN_W-1:8], rx_data};
  assign addr_inc = LEN_W'(addr_q) + LEN_W'(1);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    csum_d  = csum_q;
    hi_d    = hi_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && (rx_data == HEADER)) begin
          state_d = ST_LEN_HI;
          csum_d  = '0;
          addr_d  = '0;
        end
      end
      ST_LEN_HI: begin
        if (accept) begin
          count_d[LEN_W-1:8] = rx_data[3:0];
          state_d            = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (accept) begin
          count_d = len_new;
          state_d = (len_new != '0) ? ST_DATA_HI : ST_CHECK;
        end
      end
      ST_DATA_HI: begin
        if (accept) begin
          hi_d    = rx_data;
          csum_d  = csum_q + rx_data;
          state_d = ST_DATA_LO;
        end
      end
      ST_DATA_LO: begin
        if (accept) begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = {hi_q, rx_data};
          csum_d  = csum_q + rx_data;
          addr_d  = addr_q + ADDR_W'(1);
          // Length is capped at 4095, so the address stops before it can wrap
          state_d = (addr_inc == count_q) ? ST_CHECK : ST_DATA_HI;
        end
      end
      ST_CHECK: begin
        if (accept) begin
          state_d = (rx_data == csum_q) ? ST_DONE : ST_ERROR;
        end
      end
      ST_DONE: begin
        if (boot_req) begin
          state_d = ST_IDLE;
        end
      end
      ST_ERROR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    boot_d = (state_d != ST_DONE);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      addr_q  <= '0;
      csum_q  <= '0;
      hi_q    <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      boot_q  <= 1'b1;
    end else if (clk_valid) begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      csum_q  <= csum_d;
      hi_q    <= hi_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      boot_q  <= boot_d;
    end
  end

  // Pulses are masked while the clock enable is low: a pending write or error
  // pulse then lands on the next enabled cycle instead of stretching.
  assign imem_we       = we_q && clk_valid;
  assign boot_err      = (state_q == ST_ERROR) && clk_valid;
  assign imem_addr     = waddr_q;
  assign imem_wdata    = wdata_q;
  assign bootstrapping = boot_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: a table of directed single-cycle
// vectors for the basic frame, then hand-written multi-cycle sequences.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        clk_valid;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [11:0] imem_addr;
  logic [15:0] imem_wdata;
  logic        bootstrapping;
  logic        boot_req;
  logic        boot_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [11:0] wa[$];
  logic [15:0] wd[$];

  prog_loader #(
    .HEADER(8'hA5),
    .ADDR_W(12)
  ) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .clk_valid    (clk_valid),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .bootstrapping(bootstrapping),
    .boot_req     (boot_req),
    .boot_err     (boot_err)
  );

  always #5 clk = ~clk;

  // Memory-side view of the write port
  always @(posedge clk) begin
    if (imem_we) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
    end
  end

  typedef struct packed {
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        boot_req;
    logic        clk_valid;
    logic        exp_ready;
    logic        exp_boot;
    logic        exp_we;
    logic [11:0] exp_addr;
    logic [15:0] exp_wdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid  = 1'b1;
    rx_data   = b;
    clk_valid = 1'b1;
    boot_req  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    rx_valid  = 1'b0;
    clk_valid = 1'b1;
    boot_req  = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_boot_req();
    rx_valid  = 1'b0;
    clk_valid = 1'b1;
    boot_req  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    boot_req = 1'b0;
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic off_we;
    arst_n    = 1'b0;
    clk_valid = 1'b1;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    boot_req  = 1'b0;

    // rx_v data  breq cv | rdy boot we addr wdata err
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000, 16'h0000, 1'b0};
    vecs[1]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000, 16'h0000, 1'b0};
    vecs[2]  = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000, 16'h0000, 1'b0};
    vecs[3]  = '{1'b1, 8'h12, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000, 16'h0000, 1'b0};
    vecs[4]  = '{1'b1, 8'h34, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h000, 16'h1234, 1'b0};
    vecs[5]  = '{1'b1, 8'h56, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000, 16'h1234, 1'b0};
    vecs[6]  = '{1'b1, 8'h78, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h001, 16'h5678, 1'b0};
    vecs[7]  = '{1'b1, 8'h14, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h001, 16'h5678, 1'b0};
    vecs[8]  = '{1'b1, 8'h99, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h001, 16'h5678, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h001, 16'h5678, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h001, 16'h5678, 1'b0};

    // Reset state
    #12;
    chk("reset_outputs", {rx_ready, bootstrapping, imem_we, imem_addr, imem_wdata, boot_err},
        {1'b1, 1'b1, 1'b0, 12'h000, 16'h0000, 1'b0});
    @(negedge clk);
    arst_n = 1'b1;
    idle_cycle();

    // Basic frame, boot_req ignored in DATA_HI, then reload from DONE
    clear_log();
    for (int i = 0; i < 11; i++) begin
      rx_valid  = vecs[i].rx_valid;
      rx_data   = vecs[i].rx_data;
      boot_req  = vecs[i].boot_req;
      clk_valid = vecs[i].clk_valid;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          {rx_ready, bootstrapping, imem_we, imem_addr, imem_wdata, boot_err},
          {vecs[i].exp_ready, vecs[i].exp_boot, vecs[i].exp_we, vecs[i].exp_addr,
           vecs[i].exp_wdata, vecs[i].exp_err});
    end
    boot_req = 1'b0;
    chk("frame_write_count", 64'(wa.size()), 64'd2);

    // Bad checksum, then a correct resend
    clear_log();
    send(8'hA5); send(8'h00); send(8'h02);
    send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    send(8'h15);
    chk("err_pulse", {boot_err, bootstrapping, rx_ready}, {1'b1, 1'b1, 1'b0});
    idle_cycle();
    chk("err_back_idle", {boot_err, bootstrapping, rx_ready}, {1'b0, 1'b1, 1'b1});
    chk("err_words_kept", 64'(wa.size()), 64'd2);
    send(8'hA5); send(8'h00); send(8'h02);
    send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    send(8'h14);
    chk("resend_done", {bootstrapping, rx_ready}, {1'b0, 1'b0});
    chk("resend_writes", {32'(wa.size()), wa[2], wd[2], wa[3], wd[3]},
        {32'd4, 12'h000, 16'h1234, 12'h001, 16'h5678});
    pulse_boot_req();
    chk("reload_req", {bootstrapping, rx_ready}, {1'b1, 1'b1});

    // Leading junk and a zero-length frame
    clear_log();
    send(8'h3C); send(8'hFF); send(8'hA5);
    send(8'h00); send(8'h00); send(8'h00);
    chk("zero_len_done", {bootstrapping, rx_ready}, {1'b0, 1'b0});
    chk("zero_len_writes", 64'(wa.size()), 64'd0);
    pulse_boot_req();

    // rx_valid held while clk_valid toggles: one byte per enabled edge
    clear_log();
    off_we   = 1'b0;
    rx_valid = 1'b1;
    boot_req = 1'b0;
    foreach (vecs[k]) begin end
    for (int i = 0; i < 6; i++) begin
      logic [7:0] bytes [6];
      bytes = '{8'hA5, 8'h00, 8'h01, 8'hAB, 8'hCD, 8'h78};
      rx_data   = bytes[i];
      clk_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clk_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (imem_we) off_we = 1'b1;
    end
    rx_valid  = 1'b0;
    clk_valid = 1'b1;
    chk("gated_no_we", 64'(off_we), 64'd0);
    chk("gated_done", {bootstrapping, rx_ready}, {1'b0, 1'b0});
    chk("gated_write", {32'(wa.size()), wa[0], wd[0]}, {32'd1, 12'h000, 16'hABCD});
    pulse_boot_req();

    // Reset mid-frame after the 3rd data byte
    send(8'hA5); send(8'h00); send(8'h02);
    send(8'h11); send(8'h22); send(8'h33);
    arst_n = 1'b0;
    #2;
    chk("midframe_reset", {rx_ready, bootstrapping, imem_we, imem_addr, imem_wdata, boot_err},
        {1'b1, 1'b1, 1'b0, 12'h000, 16'h0000, 1'b0});
    @(negedge clk);
    arst_n = 1'b1;
    clear_log();
    send(8'hA5); send(8'h00); send(8'h01);
    send(8'h44); send(8'h55); send(8'h99);
    chk("post_reset_done", {bootstrapping, rx_ready}, {1'b0, 1'b0});
    chk("post_reset_write", {32'(wa.size()), wa[0], wd[0]}, {32'd1, 12'h000, 16'h4455});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
